// File: rtl/spr_gamma_pkg.sv
// Shared constants for the 10-bit gamma interpolator: level boundaries,
// LUT geometry and the segment-span to shift mapping.
package spr_gamma_pkg;

  localparam int LUT_DEPTH = 33;
  localparam int DW        = 10;
  localparam int IDX_W     = 5;
  localparam int SPAN_W    = 11;

  // Segment boundaries on the 8-bit scale; segments are 4, 2, 4, 8 or 16 levels wide.
  localparam int unsigned LEVEL [LUT_DEPTH] = '{
      0,   4,   8,  12,  16,  20,  24,  28,  32,  36,  40,  44,
     46,  50,  54,
     62,  70,  78,  86,  94, 102, 110, 118, 126,
    142, 158, 174, 190, 206, 222, 238, 254,
    256
  };

  typedef struct packed {
    logic       legal;
    logic [2:0] shift;
  } span_shift_t;

  function automatic span_shift_t span_to_shift(input logic [SPAN_W-1:0] span10);
    span_shift_t r;
    r = '0;
    case (span10)
      11'd8:   r = '{legal: 1'b1, shift: 3'd3};
      11'd16:  r = '{legal: 1'b1, shift: 3'd4};
      11'd32:  r = '{legal: 1'b1, shift: 3'd5};
      11'd64:  r = '{legal: 1'b1, shift: 3'd6};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] identity_value(input int k);
    int unsigned v;
    v = LEVEL[k] * 4;
    if (v > 1023) v = 1023;
    return DW'(v);
  endfunction

endpackage

// File: rtl/gamma_lut_33x10.sv
// Gamma LUT register array: one synchronous write port, two combinational
// read ports, loaded with the identity curve on reset.
module gamma_lut_33x10
  import spr_gamma_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH,
  parameter int WIDTH = DW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: this array is deliberately reset -- the identity curve must be live
  // straight out of reset -- so it maps to flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= WIDTH'(identity_value(k));
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-write contents when addressing a location written this cycle.
  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/gamma_interp_10bit.sv
// Three-stage piecewise-linear gamma interpolator between adjacent LUT points,
// with sync signals delayed to stay aligned with the result.
module gamma_interp_10bit #(
  parameter int LUT_DEPTH = 33,
  parameter int DW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_hs,
  input  logic          i_vs,
  input  logic          en,
  input  logic [4:0]    idx,
  input  logic [DW-1:0] pixel_in,
  input  logic [7:0]    lowLevel,
  input  logic [8:0]    highLevel,
  input  logic          lut_we,
  input  logic [5:0]    lut_addr,
  input  logic [DW-1:0] lut_wdata,
  output logic [DW-1:0] gamma_out,
  output logic          out_valid,
  output logic          o_hs,
  output logic          o_vs
);

  import spr_gamma_pkg::span_shift_t;
  import spr_gamma_pkg::span_to_shift;

  localparam int DELTA_W = 6;
  localparam int SPAN_W  = 11;
  localparam int PROD_W  = 18;

  logic          v0;
  logic [DW-1:0] lut_l0, lut_l1;

  // Stage 1
  logic               v1, hs1, vs1;
  logic [DW-1:0]      l0_1, l1_1;
  logic [DELTA_W-1:0] delta_1;
  logic [SPAN_W-1:0]  span_1;

  // Stage 2
  logic                     v2, hs2, vs2;
  logic [DW-1:0]            l0_2;
  logic signed [PROD_W-1:0] prod_2;
  span_shift_t              sh_2;

  logic signed [DW:0]       diff_1;
  logic signed [PROD_W-1:0] prod_next;
  logic signed [PROD_W-1:0] bias;
  logic signed [PROD_W-1:0] rounded;
  logic [DW-1:0]            gamma_next;

  assign v0 = en & i_hs & i_vs;

  gamma_lut_33x10 #(
    .DEPTH (LUT_DEPTH),
    .WIDTH (DW)
  ) u_lut (
    .clk    (clk),
    .rst    (rst),
    .we     (lut_we),
    .waddr  (lut_addr),
    .wdata  (lut_wdata),
    .raddr0 ({1'b0, idx}),
    .raddr1 (6'(idx) + 6'd1),
    .rdata0 (lut_l0),
    .rdata1 (lut_l1)
  );

  // NOTE: every signal driven here gets a value on every path, so no latches form.
  always_comb begin
    diff_1     = $signed({1'b0, l1_1}) - $signed({1'b0, l0_1});
    prod_next  = PROD_W'(diff_1) * PROD_W'($signed({1'b0, delta_1}));
    // Half-LSB bias for round-to-nearest; the value is ignored for illegal spans.
    bias       = PROD_W'(1) <<< (sh_2.shift - 3'd1);
    rounded    = (prod_2 + bias) >>> sh_2.shift;
    gamma_next = l0_2;
    if (sh_2.legal) gamma_next = DW'($signed({{(PROD_W-DW){1'b0}}, l0_2}) + rounded);
  end

  // NOTE: non-blocking assignments let every stage sample the previous stage's
  // old value at the same edge, which is what makes this a pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      l0_1      <= '0;
      l1_1      <= '0;
      delta_1   <= '0;
      span_1    <= '0;
      v2        <= 1'b0;
      hs2       <= 1'b0;
      vs2       <= 1'b0;
      l0_2      <= '0;
      prod_2    <= '0;
      sh_2      <= '0;
      gamma_out <= '0;
      out_valid <= 1'b0;
      o_hs      <= 1'b0;
      o_vs      <= 1'b0;
    end else begin
      v1        <= v0;
      hs1       <= i_hs;
      vs1       <= i_vs;
      l0_1      <= lut_l0;
      l1_1      <= lut_l1;
      delta_1   <= DELTA_W'(pixel_in - DW'({lowLevel, 2'b00}));
      span_1    <= {9'(highLevel - {1'b0, lowLevel}), 2'b00};

      v2        <= v1;
      hs2       <= hs1;
      vs2       <= vs1;
      l0_2      <= l0_1;
      prod_2    <= prod_next;
      sh_2      <= span_to_shift(span_1);

      out_valid <= v2;
      o_hs      <= hs2;
      o_vs      <= vs2;
      gamma_out <= v2 ? gamma_next : '0;
    end
  end

endmodule

// File: tb/tb_gamma_interp_10bit.sv
// Self-checking bench for gamma_interp_10bit: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_gamma_interp_10bit;

  logic       clk = 1'b0;
  logic       rst, i_hs, i_vs, en, lut_we;
  logic [4:0] idx;
  logic [9:0] pixel_in, lut_wdata;
  logic [7:0] lowLevel;
  logic [8:0] highLevel;
  logic [5:0] lut_addr;
  logic [9:0] gamma_out;
  logic       out_valid, o_hs, o_vs;

  always #5 clk = ~clk;

  gamma_interp_10bit dut (
    .clk       (clk),
    .rst       (rst),
    .i_hs      (i_hs),
    .i_vs      (i_vs),
    .en        (en),
    .idx       (idx),
    .pixel_in  (pixel_in),
    .lowLevel  (lowLevel),
    .highLevel (highLevel),
    .lut_we    (lut_we),
    .lut_addr  (lut_addr),
    .lut_wdata (lut_wdata),
    .gamma_out (gamma_out),
    .out_valid (out_valid),
    .o_hs      (o_hs),
    .o_vs      (o_vs)
  );

  typedef struct {
    bit valid;
    bit hs;
    bit vs;
    int gamma;
    bit bounded;
    int lo;
    int hi;
  } exp_t;

  int level [33] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44, 46, 50, 54,
                     62, 70, 78, 86, 94, 102, 110, 118, 126,
                     142, 158, 174, 190, 206, 222, 238, 254, 256};
  int   lut_m [33];
  exp_t pipe  [3];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cur_bounded;
  int   cur_idx, cur_pix, cur_low, cur_high;

  task automatic check(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int identity(input int k);
    return (level[k] * 4 > 1023) ? 1023 : level[k] * 4;
  endfunction

  // Straight-line interpolation between two LUT points, rounded to nearest.
  function automatic int interp(input int l0, input int l1, input int pix,
                                input int low, input int high);
    int span, d;
    span = (high - low) * 4;
    d    = (pix - low * 4) & 63;
    if (span == 8 || span == 16 || span == 32 || span == 64)
      return (l0 + floor_div((l1 - l0) * d + span / 2, span)) & 1023;
    return l0;
  endfunction

  task automatic drive(input bit e, input bit hs, input bit vs, input int ix,
                       input int pix, input int low, input int high, input bit bnd);
    en = e; i_hs = hs; i_vs = vs;
    idx = 5'(ix); pixel_in = 10'(pix); lowLevel = 8'(low); highLevel = 9'(high);
    cur_idx = ix; cur_pix = pix; cur_low = low; cur_high = high; cur_bounded = bnd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic set_write(input int addr, input int data);
    lut_we = 1'b1; lut_addr = 6'(addr); lut_wdata = 10'(data);
  endtask

  // One clock: predict with the current model state, advance, compare.
  task automatic tick();
    exp_t e;
    int   l0, l1;
    l0 = lut_m[cur_idx];
    l1 = lut_m[cur_idx + 1];
    e.valid   = en && i_hs && i_vs;
    e.hs      = i_hs;
    e.vs      = i_vs;
    e.gamma   = e.valid ? interp(l0, l1, cur_pix, cur_low, cur_high) : 0;
    e.bounded = cur_bounded;
    e.lo      = (l0 < l1) ? l0 : l1;
    e.hi      = (l0 < l1) ? l1 : l0;
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 33; k++) lut_m[k] = identity(k);
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e;
      if (lut_we && lut_addr <= 6'd32) lut_m[lut_addr] = int'(lut_wdata);
    end
    @(posedge clk);
    #1;
    lut_we = 1'b0;
    check("out_valid", int'(out_valid), int'(pipe[2].valid));
    check("o_hs", int'(o_hs), int'(pipe[2].hs));
    check("o_vs", int'(o_vs), int'(pipe[2].vs));
    check("gamma_out", int'(gamma_out), pipe[2].gamma);
    if (pipe[2].valid && pipe[2].bounded)
      check("bound", int'(int'(gamma_out) >= pipe[2].lo && int'(gamma_out) <= pipe[2].hi), 1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0, 0, 0};
    rst = 1'b1; lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
    idle();
    tick();
    tick();
    check("rst_gamma", int'(gamma_out), 0);
    check("rst_valid", int'(out_valid), 0);
    rst = 1'b0;

    // Identity curve reproduces the input level.
    drive(1, 1, 1, 6, 100, 24, 28, 1); tick();
    idle(); tick(); tick();
    check("identity_100", int'(gamma_out), 100);
    check("identity_valid", int'(out_valid), 1);

    // Falling segment after LUT writes.
    idle(); set_write(6, 200); tick();
    set_write(7, 100); tick();
    drive(1, 1, 1, 6, 104, 24, 28, 1); tick();
    idle(); tick(); tick();
    check("written_150", int'(gamma_out), 150);

    // Top segment reads lut[32] without wrapping.
    drive(1, 1, 1, 31, 1023, 254, 256, 1); tick();
    idle(); tick(); tick();
    check("top_1022", int'(gamma_out), 1022);

    // Same-cycle write returns the old value; new value one cycle later.
    drive(1, 1, 1, 6, 96, 24, 28, 1); set_write(6, 300); tick();
    tick();
    idle(); tick();
    check("rdw_old", int'(gamma_out), 200);
    tick();
    check("rdw_new", int'(gamma_out), 300);

    // Horizontal blanking gap mid-stream.
    for (int j = 0; j < 10; j++) begin
      drive(1, (j != 3 && j != 4), 1, 6, 100, 24, 28, 1);
      tick();
      if (j >= 2) begin
        check("gap_valid", int'(out_valid), int'(!(j == 5 || j == 6)));
        check("gap_hs", int'(o_hs), int'(!(j == 5 || j == 6)));
      end
    end

    // Zero span passes L0 through; out-of-range write is dropped.
    idle(); set_write(0, 37); tick();
    drive(1, 1, 1, 0, 5, 0, 0, 0); tick();
    idle(); tick(); tick();
    check("zero_span", int'(gamma_out), 37);
    set_write(40, 555); tick();
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, 1, i, level[i] * 4, level[i], level[i + 1], 1);
      tick();
    end
    idle(); tick(); tick();

    // Reset with data in flight and a competing write.
    set_write(6, 200); tick();
    drive(1, 1, 1, 6, 104, 24, 28, 1); tick();
    tick();
    rst = 1'b1; set_write(6, 500); tick();
    check("rst_flush_gamma", int'(gamma_out), 0);
    check("rst_flush_valid", int'(out_valid), 0);
    check("rst_flush_hs", int'(o_hs), 0);
    rst = 1'b0;
    drive(1, 1, 1, 6, 96, 24, 28, 1); tick();
    idle(); tick(); tick();
    check("rst_lut6", int'(gamma_out), 96);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int ix, lo_l, hi_l, pmax;
      ix = int'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) begin
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
              ix, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 511)), 0);
      end else begin
        lo_l = level[ix];
        hi_l = level[ix + 1];
        pmax = (hi_l * 4 - 1 > 1023) ? 1023 : hi_l * 4 - 1;
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
              ix, int'($urandom_range(lo_l * 4, pmax)), lo_l, hi_l, 1);
      end
      if ($urandom_range(0, 9) == 0)
        set_write(int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)));
      tick();
    end
    idle(); tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
